// File: rtl/cdl_crc_pkg.sv
// Shared CRC-16 definitions for the CDL transmit and receive paths.
package cdl_crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CRC     = 2'd2
   } cdl_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam int          CRC16_LEN  = 16;

endpackage

// File: rtl/cdl_crc16_step.sv
// One-bit CRC-16 update, purely combinational so TX and RX share it.
module cdl_crc16_step
   import cdl_crc_pkg::*;
(
   input  logic [15:0] i_crc,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic w_fb;

   assign w_fb  = i_crc[15] ^ i_bit;
   assign o_crc = {i_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/cdl_tx_crc16.sv
// Serial CRC-16 generator: passes payload bits through, then emits the inverted CRC MSB-first.
module cdl_tx_crc16
   import cdl_crc_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        shift_strobe,
   input  logic        data_bit,
   input  logic        data_last,
   input  logic        abort,
   output logic        tx_bit,
   output logic        tx_active,
   output logic        data_req,
   output logic        crc_done,
   output logic [15:0] crc_value
);

   cdl_state_t  r_state;
   cdl_state_t  w_nextState;
   logic [15:0] r_crc;
   logic [15:0] w_crcStep;
   logic [3:0]  r_cnt;
   logic        r_txBit;
   logic        r_crcDone;
   logic        w_lastCrcBit;

   cdl_crc16_step u_step (
      .i_crc (r_crc),
      .i_bit (data_bit),
      .o_crc (w_crcStep)
   );

   assign w_lastCrcBit = (r_state == ST_CRC) && shift_strobe &&
                         (r_cnt == 4'(CRC16_LEN - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Abort outranks everything, including a start or strobe in the same cycle.
   always_comb begin
      w_nextState = r_state;
      if (abort) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (start) w_nextState = ST_PAYLOAD;
            ST_PAYLOAD: if (shift_strobe && data_last) w_nextState = ST_CRC;
            ST_CRC:     if (w_lastCrcBit) w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_crc     <= CRC16_INIT;
         r_cnt     <= 4'd0;
         r_txBit   <= 1'b1;
         r_crcDone <= 1'b0;
      end else begin
         r_crcDone <= 1'b0;
         if (abort) begin
            r_txBit <= 1'b1;
            r_cnt   <= 4'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_txBit <= 1'b1;
                  if (start) begin
                     r_crc <= CRC16_INIT;
                  end
               end
               ST_PAYLOAD: begin
                  if (shift_strobe) begin
                     r_txBit <= data_bit;
                     r_crc   <= w_crcStep;
                     if (data_last) begin
                        r_cnt <= 4'd0;
                     end
                  end
               end
               // Shifting ones in leaves the register at CRC16_INIT once all bits are out.
               ST_CRC: begin
                  if (shift_strobe) begin
                     r_txBit   <= ~r_crc[15];
                     r_crc     <= {r_crc[14:0], 1'b1};
                     r_cnt     <= r_cnt + 4'd1;
                     r_crcDone <= w_lastCrcBit;
                  end
               end
               default: r_txBit <= 1'b1;
            endcase
         end
      end
   end

   assign tx_bit    = r_txBit;
   assign crc_done  = r_crcDone;
   assign crc_value = r_crc;
   assign tx_active = (r_state == ST_PAYLOAD) || (r_state == ST_CRC);
   assign data_req  = (r_state == ST_PAYLOAD);

endmodule
